// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and
// the load lane-select / extension helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Picks the addressed lane(s) out of a stored word and extends to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size,
                                              input logic        is_unsigned);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: result = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SIZE_HALF: result = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default:   result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dmem_be_ram.sv
// Word-wide RAM with per-byte write enables and combinational read.
// Contents start at zero and are never touched by reset.
module dmem_be_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [3:0]       byte_en,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        mem[index][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_memory_sized.sv
// Sized load/store data memory with a valid/ready request port and a
// fixed-latency single-cycle response pulse.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        resp_valid,
  output logic [31:0] read_data,
  output logic        resp_error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  count_q, count_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] read_data_q, read_data_d;
  logic        resp_error_q, resp_error_d;

  logic        accept;
  logic        illegal, misaligned, out_of_range, req_err;
  logic [3:0]  lane_en;
  logic [3:0]  ram_be;
  logic [31:0] wr_lanes;
  logic [31:0] rd_word;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  assign illegal      = (req_size == 2'b11);
  assign misaligned   = ((req_size == SIZE_HALF) && address[0]) ||
                        ((req_size == SIZE_WORD) && (address[1:0] != 2'b00));
  assign out_of_range = |address[31:IDX_W+2];
  assign req_err      = illegal || misaligned || out_of_range;

  // Store data is right-aligned, so replicate it across lanes and let the
  // byte enables pick which copy lands.
  always_comb begin
    lane_en  = 4'b0000;
    wr_lanes = write_data;
    case (req_size)
      SIZE_BYTE: begin
        lane_en             = 4'b0000;
        lane_en[address[1:0]] = 1'b1;
        wr_lanes            = {4{write_data[7:0]}};
      end
      SIZE_HALF: begin
        lane_en  = address[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{write_data[15:0]}};
      end
      SIZE_WORD: lane_en = 4'b1111;
      default:   lane_en = 4'b0000;
    endcase
  end

  assign ram_be = (accept && req_write && !req_err) ? lane_en : 4'b0000;

  dmem_be_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk     (clk),
    .byte_en (ram_be),
    .index   (address[IDX_W+1:2]),
    .wdata   (wr_lanes),
    .rdata   (rd_word)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    resp_valid_d = 1'b0;
    read_data_d  = read_data_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          resp_error_d = req_err;
          read_data_d  = (req_err || req_write) ? 32'h0
                         : extend_load(rd_word, address[1:0], req_size, req_unsigned);
          if (LATENCY == 1) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            count_d      = 3'd0;
          end else begin
            state_d = WAIT;
            count_d = 3'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (count_q <= 3'd1) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          count_d      = 3'd0;
        end else begin
          count_d = count_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= 3'd0;
      resp_valid_q <= 1'b0;
      read_data_q  <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      resp_valid_q <= resp_valid_d;
      read_data_q  <= read_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign read_data  = read_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: one LATENCY=1 and one LATENCY=3 instance,
// each checked against a byte-array reference model.
module tb_data_memory_sized;

  localparam int DEPTH = 1024;
  localparam int BYTES = DEPTH * 4;

  logic        clk;
  logic        reset;
  logic        valid_a, valid_b;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic        bus_unsigned;
  logic [31:0] bus_addr;
  logic [31:0] bus_data;

  logic        ready_a, ready_b;
  logic        rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rerr_a, rerr_b;

  int num_asserts;
  int num_failures;

  logic [7:0] model [2][BYTES];

  data_memory_sized #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (valid_a),
    .req_ready    (ready_a),
    .req_write    (bus_write),
    .req_size     (bus_size),
    .req_unsigned (bus_unsigned),
    .address      (bus_addr),
    .write_data   (bus_data),
    .resp_valid   (rvalid_a),
    .read_data    (rdata_a),
    .resp_error   (rerr_a)
  );

  data_memory_sized #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (valid_b),
    .req_ready    (ready_b),
    .req_write    (bus_write),
    .req_size     (bus_size),
    .req_unsigned (bus_unsigned),
    .address      (bus_addr),
    .write_data   (bus_data),
    .resp_valid   (rvalid_b),
    .read_data    (rdata_b),
    .resp_error   (rerr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_asserts++;
    assert (observed === expected)
    else begin
      num_failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic scrambleBus();
    bus_write    = 1'b1;
    bus_size     = 2'b10;
    bus_unsigned = 1'($urandom_range(0, 1));
    bus_addr     = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
    bus_data     = $urandom;
  endtask

  // One full transaction on instance inst (0: latency 1, 1: latency 3).
  task automatic applyStimulus(input int inst, input logic wr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] data, input bit hold_valid);
    int          lat;
    int          n_bytes;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [31:0] shifted;
    lat      = (inst == 0) ? 1 : 3;
    n_bytes  = 1 << size;
    exp_err  = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'(BYTES));
    exp_data = 32'h0;
    if (!exp_err && !wr) begin
      for (int i = 0; i < n_bytes; i++)
        exp_data = exp_data | ({24'b0, model[inst][int'(addr) + i]} << (8 * i));
      if (!uns && n_bytes < 4 && exp_data[8 * n_bytes - 1])
        exp_data = exp_data - (32'd1 << (8 * n_bytes));
    end
    if (!exp_err && wr) begin
      for (int i = 0; i < n_bytes; i++) begin
        shifted = data >> (8 * i);
        model[inst][int'(addr) + i] = shifted[7:0];
      end
    end

    checkOutput("ready_before", 32'((inst == 0) ? ready_a : ready_b), 32'd1);
    bus_write    = wr;
    bus_size     = size;
    bus_unsigned = uns;
    bus_addr     = addr;
    bus_data     = data;
    if (inst == 0) valid_a = 1'b1; else valid_b = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < lat; k++) begin
      if (!hold_valid) begin
        valid_a = 1'b0;
        valid_b = 1'b0;
      end
      scrambleBus();
      checkOutput("ready_busy", 32'((inst == 0) ? ready_a : ready_b), 32'd0);
      checkOutput("resp_valid_timing", 32'((inst == 0) ? rvalid_a : rvalid_b),
                  32'(k == lat - 1));
      if (k == lat - 1) begin
        checkOutput("read_data", (inst == 0) ? rdata_a : rdata_b, exp_data);
        checkOutput("resp_error", 32'((inst == 0) ? rerr_a : rerr_b), 32'(exp_err));
      end
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    checkOutput("resp_valid_after", 32'((inst == 0) ? rvalid_a : rvalid_b), 32'd0);
    checkOutput("ready_after", 32'((inst == 0) ? ready_a : ready_b), 32'd1);
  endtask

  task automatic randomRequest(input int inst);
    logic [31:0] addr;
    int          pick;
    pick = $urandom_range(0, 9);
    if (pick < 8)       addr = 32'($urandom_range(0, 63));
    else if (pick == 8) addr = $urandom;
    else                addr = 32'(BYTES - 4) + 32'($urandom_range(0, 7));
    applyStimulus(inst, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), addr, $urandom, bit'($urandom_range(0, 1)));
  endtask

  initial begin
    num_asserts  = 0;
    num_failures = 0;
    for (int m = 0; m < 2; m++)
      for (int b = 0; b < BYTES; b++)
        model[m][b] = 8'h00;
    reset        = 1'b1;
    valid_a      = 1'b0;
    valid_b      = 1'b0;
    bus_write    = 1'b0;
    bus_size     = 2'b00;
    bus_unsigned = 1'b0;
    bus_addr     = 32'h0;
    bus_data     = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_resp_valid_a", 32'(rvalid_a), 32'd0);
    checkOutput("reset_resp_valid_b", 32'(rvalid_b), 32'd0);
    checkOutput("reset_read_data_b", rdata_b, 32'h0);
    checkOutput("reset_resp_error_b", 32'(rerr_b), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_ready_a", 32'(ready_a), 32'd1);
    checkOutput("reset_ready_b", 32'(ready_b), 32'd1);
    @(posedge clk); #1;

    // Directed word/byte store-load sequence on the single-cycle instance.
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 1'b0);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h12345678, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h1000, 32'hCAFEF00D, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 2'b01, 1'b0, 32'hFFE, 32'h0000A5C3, 1'b1);
    applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'hFFE, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0, 1'b0);

    // Multi-cycle instance with req_valid held through the busy window.
    applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 1'b1);
    applyStimulus(1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 1'b1);

    // Reset in the cycle after a load is accepted drops the response.
    bus_write = 1'b0; bus_size = 2'b10; bus_unsigned = 1'b0; bus_addr = 32'h20;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    reset   = 1'b1;
    #1;
    checkOutput("rst_wait_resp_valid", 32'(rvalid_b), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("rst_hold_resp_valid", 32'(rvalid_b), 32'd0);
    end
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_no_resp", 32'(rvalid_b), 32'd0);
      checkOutput("post_rst_ready", 32'(ready_b), 32'd1);
    end
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

    // Reset asserted mid-cycle while the response is showing clears it at once.
    bus_write = 1'b0; bus_size = 2'b10; bus_unsigned = 1'b0; bus_addr = 32'h20;
    valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resp_before_rst", 32'(rvalid_b), 32'd1);
    checkOutput("data_before_rst", rdata_b, 32'h12345678);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_resp_valid", 32'(rvalid_b), 32'd0);
    checkOutput("async_rst_read_data", rdata_b, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("async_rst_idle_ready", 32'(ready_b), 32'd1);

    for (int n = 0; n < 60; n++) randomRequest(0);
    for (int n = 0; n < 40; n++) randomRequest(1);
    for (int w = 0; w < 16; w++) begin
      applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, 1'b0);
      applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'(w * 4), 32'h0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             num_asserts, num_failures);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words; SHALL be a power of two, at least 4.
REQ-002 Parameter LATENCY, default 1, cycles from request acceptance to response; legal range 1..4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
REQ-010 address  input  32  byte address.
REQ-011 write_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 resp_valid  output  1  one-cycle response pulse.
REQ-013 read_data  output  32  extended load result; valid only while resp_valid is high.
REQ-014 resp_error  output  1  request was misaligned, out of range or illegal; valid only while resp_valid is high.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high.
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be high only in IDLE.
REQ-017 On acceptance, the FSM SHALL go to RESP if LATENCY = 1, otherwise to WAIT with a counter loaded to LATENCY-1.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP when the count reaches 1.
REQ-019 RESP SHALL hold resp_valid high for exactly one cycle, then return to IDLE; throughput is one request per LATENCY+1 cycles.
REQ-020 Word index SHALL be address[log2(DEPTH_WORDS)+1:2]; out of range SHALL be address[31:log2(DEPTH_WORDS)+2] != 0.
REQ-021 Misaligned SHALL be half with address[0]=1, or word with address[1:0] != 00.
REQ-022 An erroring request SHALL write nothing, return read_data = 0, and set resp_error = 1.
REQ-023 A legal store SHALL commit on the acceptance edge, using byte enables: byte -> lane address[1:0]; half -> lanes {address[1],0} and {address[1],1}; word -> all four lanes.
REQ-024 A legal load SHALL sample the addressed word on the acceptance edge, select lane(s) by address[1:0], extend per req_unsigned, and hold the result in a register until the response.
REQ-025 A store response SHALL return read_data = 0 and resp_error = 0.
REQ-026 req_valid outside IDLE SHALL be ignored; inputs SHALL only be sampled on acceptance.
REQ-027 Memory contents SHALL initialise to zero at time zero.

Reset
REQ-028 reset SHALL force, asynchronously: state IDLE, counter 0, resp_valid 0, read_data 0, resp_error 0, req_ready 1 while reset is deasserted in IDLE.
REQ-029 reset SHALL NOT clear the memory array; a store committed before reset SHALL persist.
REQ-030 Reset during WAIT or RESP SHALL drop the pending response; no resp_valid pulse SHALL follow.

Structure
REQ-031 Package dmem_pkg SHALL hold the size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD and the FSM state enum.
REQ-032 Sub-module dmem_be_ram SHALL implement a DEPTH_WORDS x 32 array with 4-bit byte-enable synchronous write and combinational read; it SHALL contain no reset.

Verification
REQ-033 LATENCY=1: store word 0xDEADBEEF to 0x10, then load word from 0x10 -> resp_valid 1 cycle after each accept; read_data 0xDEADBEEF; resp_error 0.
REQ-034 Store byte 0x80 to 0x13, then load byte signed from 0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word from 0x10 -> 0x80ADBEEF.
REQ-035 Load half from 0x11, load word from 0x12, and any req_size=11 request -> resp_error 1, read_data 0, memory unchanged.
REQ-036 DEPTH_WORDS=1024: store word to 0x1000 -> resp_error 1; then load word from 0x0 -> 0x00000000, showing no aliasing.
REQ-037 LATENCY=3: accept at edge N -> req_ready low N+1..N+3, resp_valid high only in cycle N+3; req_valid held high during this time accepts nothing.
REQ-038 LATENCY=3: store then load, assert reset in the cycle after the load is accepted -> no resp_valid; after reset the load returns the stored value.
